// File: rtl/ser_rx_frame.sv
// Framed serial-to-parallel receiver: strips start/parity/stop bits and
// presents each good word through a single-entry valid/ready buffer.
module ser_rx_frame #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          PARITY_EN = 1'b1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_i,
  input  logic              bit_vld_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_vld_o,
  input  logic              data_rdy_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_W-1:0]   sr, sr_nxt;
  logic                perr, perr_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                data_vld_nxt;
  logic                parity_err_nxt;
  logic                frame_err_nxt;
  logic                overrun_nxt;
  logic                busy_nxt;
  logic                commit;
  logic                drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sr           <= '0;
      perr         <= 1'b0;
      data_o       <= '0;
      data_vld_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sr           <= sr_nxt;
      perr         <= perr_nxt;
      data_o       <= data_nxt;
      data_vld_o   <= data_vld_nxt;
      parity_err_o <= parity_err_nxt;
      frame_err_o  <= frame_err_nxt;
      overrun_o    <= overrun_nxt;
      busy_o       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sr_nxt         = sr;
    perr_nxt       = perr;
    data_nxt       = data_o;
    data_vld_nxt   = data_vld_o;
    parity_err_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    overrun_nxt    = 1'b0;
    commit         = 1'b0;
    drain          = data_vld_o & data_rdy_i;

    // Framing FSM advances only on qualified bits; gaps simply hold everything.
    if (bit_vld_i) begin
      unique case (state)
        IDLE: begin
          if (!bit_i) begin
            cnt_nxt   = '0;
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (MSB_FIRST) sr_nxt = {sr[DATA_W-2:0], bit_i};
          else           sr_nxt = {bit_i, sr[DATA_W-1:1]};
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state_nxt = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          perr_nxt  = bit_i ^ (^sr);
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (!bit_i)    frame_err_nxt  = 1'b1;
          else if (perr) parity_err_nxt = 1'b1;
          else           commit         = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Single-entry buffer: a same-cycle drain frees the slot for a new commit.
    if (commit) begin
      if (!data_vld_o || drain) begin
        data_nxt     = sr;
        data_vld_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (drain) begin
      data_vld_nxt = 1'b0;
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_ser_rx_frame.sv
// Randomized bench for ser_rx_frame against a frame-level reference model.
module tb_ser_rx_frame;

  localparam int K_GOOD = 0;
  localparam int K_PERR = 1;
  localparam int K_FERR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in, bit_vld, rdy;
  logic [7:0] data;
  logic       data_vld, parity_err, frame_err, overrun, busy;

  logic       l_bit, l_vld, l_rdy;
  logic [7:0] l_data;
  logic       l_data_vld, l_perr, l_ferr, l_ovr, l_busy;

  int checks   = 0;
  int failures = 0;

  logic        m_vld;
  logic [7:0]  m_data;
  int unsigned rdy_pct;

  always #5 clk = ~clk;

  ser_rx_frame #(.DATA_W(8), .PARITY_EN(1'b1), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .bit_i(bit_in), .bit_vld_i(bit_vld),
    .data_o(data), .data_vld_o(data_vld), .data_rdy_i(rdy),
    .parity_err_o(parity_err), .frame_err_o(frame_err),
    .overrun_o(overrun), .busy_o(busy)
  );

  ser_rx_frame #(.DATA_W(8), .PARITY_EN(1'b0), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .bit_i(l_bit), .bit_vld_i(l_vld),
    .data_o(l_data), .data_vld_o(l_data_vld), .data_rdy_i(l_rdy),
    .parity_err_o(l_perr), .frame_err_o(l_ferr),
    .overrun_o(l_ovr), .busy_o(l_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; the model updates from the frame outcome the driver knows.
  task automatic step(input logic v, input logic b, input logic stop_edge,
                      input int kind, input logic [7:0] word, input logic busy_exp);
    logic r, drain, e_pe, e_fe, e_ov;
    r       = ($urandom_range(99) < rdy_pct);
    bit_vld = v;
    bit_in  = b;
    rdy     = r;
    @(posedge clk);
    drain = m_vld & r;
    e_pe  = stop_edge && (kind == K_PERR);
    e_fe  = stop_edge && (kind == K_FERR);
    e_ov  = 1'b0;
    if (stop_edge && kind == K_GOOD) begin
      if (!m_vld || drain) begin
        m_data = word;
        m_vld  = 1'b1;
      end else begin
        e_ov = 1'b1;
      end
    end else if (drain) begin
      m_vld = 1'b0;
    end
    #1;
    check("data_vld", 32'(data_vld), 32'(m_vld));
    check("data", 32'(data), 32'(m_data));
    check("parity_err", 32'(parity_err), 32'(e_pe));
    check("frame_err", 32'(frame_err), 32'(e_fe));
    check("overrun", 32'(overrun), 32'(e_ov));
    check("busy", 32'(busy), 32'(busy_exp));
  endtask

  task automatic send_frame(input logic [7:0] word, input logic flip,
                            input logic stop_bit, input int unsigned max_gap);
    logic fb[11];
    int   kind;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = word[7-i];
    fb[9]  = (^word) ^ flip;
    fb[10] = stop_bit;
    kind = !stop_bit ? K_FERR : (flip ? K_PERR : K_GOOD);
    for (int k = 0; k < 11; k++) begin
      repeat ($urandom_range(max_gap)) step(1'b0, 1'($urandom), 1'b0, kind, word, 1'(k > 0));
      step(1'b1, fb[k], 1'(k == 10), kind, word, 1'(k != 10));
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(1'($urandom_range(1)), 1'b1, 1'b0, K_GOOD, 8'h00, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic lb[15];
    rst = 1'b1; bit_vld = 1'b0; bit_in = 1'b1; rdy = 1'b0;
    l_bit = 1'b1; l_vld = 1'b0; l_rdy = 1'b0;
    m_vld = 1'b0; m_data = 8'h00; rdy_pct = 100;

    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", 32'(data_vld), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errs", 32'({parity_err, frame_err, overrun}), 32'd0);
    rst = 1'b0;

    // Directed frames: start bit on the very first edge after reset release.
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check("a5_word", 32'(data), 32'hA5);
    check("a5_vld", 32'(data_vld), 32'd1);
    idle(2);
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    check("3c_word", 32'(data), 32'h3C);
    send_frame(8'hA5, 1'b0, 1'b0, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 1);
    check("3c_after_ferr", 32'(data), 32'h3C);

    // Backpressure: second word overruns, first held until drained.
    idle(1);
    rdy_pct = 0;
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 0);
    check("held_word", 32'(data), 32'h11);
    rdy_pct = 100;
    step(1'b0, 1'b1, 1'b0, K_GOOD, 8'h00, 1'b0);
    check("drained", 32'(data_vld), 32'd0);

    // Reset mid-frame with a word buffered.
    rdy_pct = 0;
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, K_GOOD, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom), 1'b0, K_GOOD, 8'h00, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_vld", 32'(data_vld), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_errs", 32'({parity_err, frame_err, overrun}), 32'd0);
    m_vld = 1'b0; m_data = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_pct = 50;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, K_GOOD, 8'h00, 1'b0);

    // Randomized frames with random gaps and consumer throttling.
    for (int f = 0; f < 300; f++) begin
      case ($urandom_range(2))
        0:       rdy_pct = 15;
        1:       rdy_pct = 60;
        default: rdy_pct = 100;
      endcase
      send_frame(8'($urandom), 1'($urandom_range(3) == 0), 1'($urandom_range(7) != 0),
                 $urandom_range(2));
      idle($urandom_range(2));
    end
    bit_vld = 1'b0;

    // LSB-first, no parity, bits on every third cycle.
    lb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 15; k++) begin
      l_vld = 1'b1; l_bit = lb[k];
      @(posedge clk);
      #1;
      l_vld = 1'b0; l_bit = 1'($urandom);
      if (k == 4) check("lsb_idle_busy", 32'(l_busy), 32'd0);
      if (k == 9) check("lsb_mid_busy", 32'(l_busy), 32'd1);
      if (k < 14) check("lsb_no_vld", 32'(l_data_vld), 32'd0);
      repeat (2) @(posedge clk);
      #1;
    end
    check("lsb_vld", 32'(l_data_vld), 32'd1);
    check("lsb_word", 32'(l_data), 32'hAA);
    check("lsb_busy_end", 32'(l_busy), 32'd0);
    check("lsb_errs", 32'({l_perr, l_ferr, l_ovr}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
